// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1RW+1R SRAM model.
package sram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int LAT_MAX = 2;
  localparam int MAX_DW  = 256;

  // Write-first lane merge: bit b follows new_w when its lane (b / lane_w) is enabled.
  function automatic logic [MAX_DW-1:0] lane_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_DW-1:0] mask,
                                                   input int unsigned       lane_w);
    logic [MAX_DW-1:0] r;
    int unsigned       li;
    r = old_w;
    for (int unsigned b = 0; b < MAX_DW; b++) begin
      li = b / lane_w;
      if (mask[li[7:0]]) r[b[7:0]] = new_w[b[7:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: carries data, valid and collision through LAT stages; data holds between strobes.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic          coll_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          coll_o
);

  if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
    $error("sram_rd_pipe: LAT must be 1..%0d", LAT_MAX);
  end

  logic [DW-1:0]  data_q [LAT];
  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] coll_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) data_q[k] <= '0;
      valid_q <= '0;
      coll_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      coll_q[0]  <= valid_i & coll_i;
      if (valid_i) data_q[0] <= data_i;
      for (int k = 1; k < LAT; k++) begin
        valid_q[k] <= valid_q[k-1];
        coll_q[k]  <= coll_q[k-1];
        if (valid_q[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign coll_o  = coll_q[LAT-1];
  assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R SRAM with post-reset clear engine, read-valid strobes and write-first port bypass.
// Handshake: a read is accepted on any RUN-state edge with chip select low; dout*_valid pulses once when its data lands.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int LANE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             init_busy,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             dout0_valid,
  input  logic                             csb1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  output logic [DATA_WIDTH-1:0]            dout1,
  output logic                             dout1_valid,
  output logic                             collision
);

  localparam int     DEPTH     = 2 ** ADDR_WIDTH;
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  if (DATA_WIDTH > MAX_DW || DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_width
    $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of LANE_WIDTH and <= %0d", MAX_DW);
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    clr_we;
  logic                    run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      if (ptr_q == '1) state_d = ST_RUN;
    end
  end

  always_comb begin
    clr_we    = (state_q == ST_CLEAR);
    run       = (state_q == ST_RUN);
    init_busy = clr_we;
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_en, rd0_en, rd1_en, coll1;
  logic [MAX_DW-1:0]     merged_full;
  logic [DATA_WIDTH-1:0] wr_data, rd1_data;
  logic                  unused_merge, unused_coll0;

  assign wr_en  = run & ~csb0 & ~web0;
  assign rd0_en = run & ~csb0 & web0;
  assign rd1_en = run & ~csb1;

  assign merged_full  = lane_merge(MAX_DW'(mem[addr0]), MAX_DW'(din0), MAX_DW'(wmask0),
                                   LANE_WIDTH);
  assign wr_data      = merged_full[DATA_WIDTH-1:0];
  assign unused_merge = ^merged_full;

  // Same-address port 1 read sees the word as it will be after this edge's write.
  assign coll1    = wr_en & (|wmask0) & (addr0 == addr1);
  assign rd1_data = coll1 ? wr_data : mem[addr1];

  always_ff @(posedge clk) begin
    if (clr_we)     mem[ptr_q] <= '0;
    else if (wr_en) mem[addr0] <= wr_data;
  end

  sram_rd_pipe #(.DW(DATA_WIDTH), .LAT(READ_LATENCY)) u_pipe0 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd0_en),
    .data_i  (mem[addr0]),
    .coll_i  (1'b0),
    .valid_o (dout0_valid),
    .data_o  (dout0),
    .coll_o  (unused_coll0)
  );

  sram_rd_pipe #(.DW(DATA_WIDTH), .LAT(READ_LATENCY)) u_pipe1 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd1_en),
    .data_i  (rd1_data),
    .coll_i  (coll1),
    .valid_o (dout1_valid),
    .data_o  (dout1),
    .coll_o  (collision)
  );

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: three configurations checked each cycle against a timestamped read-return model.
module tb_sram_1rw1r_param;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // set A drives u_a (latency 1) and u_b (latency 2); set C drives the 64-bit u_c
  logic          csb0_a, web0_a, csb1_a;
  logic [3:0]    wmask0_a;
  logic [AW-1:0] addr0_a, addr1_a;
  logic [31:0]   din0_a;
  logic [31:0]   dout0_a, dout1_a, dout0_b, dout1_b;
  logic          v0_a, v1_a, coll_a, busy_a, v0_b, v1_b, coll_b, busy_b;

  logic          csb0_c, web0_c, csb1_c;
  logic [3:0]    wmask0_c;
  logic [AW-1:0] addr0_c, addr1_c;
  logic [63:0]   din0_c, dout0_c, dout1_c;
  logic          v0_c, v1_c, coll_c, busy_c;

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LANE_WIDTH(8),
                     .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst(rst), .init_busy(busy_a),
    .csb0(csb0_a), .web0(web0_a), .wmask0(wmask0_a), .addr0(addr0_a), .din0(din0_a),
    .dout0(dout0_a), .dout0_valid(v0_a),
    .csb1(csb1_a), .addr1(addr1_a), .dout1(dout1_a), .dout1_valid(v1_a), .collision(coll_a));

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LANE_WIDTH(8),
                     .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .rst(rst), .init_busy(busy_b),
    .csb0(csb0_a), .web0(web0_a), .wmask0(wmask0_a), .addr0(addr0_a), .din0(din0_a),
    .dout0(dout0_b), .dout0_valid(v0_b),
    .csb1(csb1_a), .addr1(addr1_a), .dout1(dout1_b), .dout1_valid(v1_b), .collision(coll_b));

  sram_1rw1r_param #(.DATA_WIDTH(64), .ADDR_WIDTH(AW), .LANE_WIDTH(16),
                     .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_c (
    .clk(clk), .rst(rst), .init_busy(busy_c),
    .csb0(csb0_c), .web0(web0_c), .wmask0(wmask0_c), .addr0(addr0_c), .din0(din0_c),
    .dout0(dout0_c), .dout0_valid(v0_c),
    .csb1(csb1_c), .addr1(addr1_c), .dout1(dout1_c), .dout1_valid(v1_c), .collision(coll_c));

  // ---------------- reference model / scoreboard ----------------
  // Ports: 0/1 = u_a port0/port1, 2/3 = u_b, 4/5 = u_c.
  typedef struct {
    int          port;
    int          cyc;
    logic [63:0] data;
    logic        coll;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mdl [2][DEPTH];
  logic [63:0] last_v [6];
  int          cyc, busy_rem, n_vec, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mmerge(input logic [63:0] o, input logic [63:0] n,
                                         input logic [3:0] m, input int lw);
    logic [63:0] r, lm;
    r = o;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        lm = ((64'd1 << lw) - 64'd1) << (i * lw);
        r  = (r & ~lm) | (n & lm);
      end
    end
    return r;
  endfunction

  task automatic push(input int p, input int c, input logic [63:0] d, input logic co);
    exp_t e;
    e.port = p; e.cyc = c; e.data = d; e.coll = co;
    exp_q.push_back(e);
  endtask

  task automatic apply(input int s, input logic csb0, input logic web0, input logic [3:0] m,
                       input logic [AW-1:0] a0, input logic [63:0] d0,
                       input logic csb1, input logic [AW-1:0] a1);
    int          lw, pb;
    logic        wr, c;
    logic [63:0] nw, d;
    lw = (s == 0) ? 8 : 16;
    pb = (s == 0) ? 0 : 4;
    wr = !csb0 && !web0;
    nw = mmerge(mdl[s][a0], d0, m, lw);
    if (!csb0 && web0) begin
      push(pb, cyc, mdl[s][a0], 1'b0);
      if (s == 0) push(2, cyc + 1, mdl[s][a0], 1'b0);
    end
    if (!csb1) begin
      c = wr && (m != 4'd0) && (a0 == a1);
      d = c ? nw : mdl[s][a1];
      push(pb + 1, cyc, d, c);
      if (s == 0) push(3, cyc + 1, d, c);
    end
    if (wr) mdl[s][a0] = nw;
  endtask

  task automatic check_port(input int p, input logic v, input logic [63:0] d, input logic co);
    int idx;
    idx = -1;
    foreach (exp_q[i]) if (exp_q[i].port == p && exp_q[i].cyc == cyc) idx = i;
    if (idx >= 0) begin
      chk($sformatf("p%0d_valid", p), 64'(v), 64'd1);
      chk($sformatf("p%0d_data", p), d, exp_q[idx].data);
      if (p % 2 == 1) chk($sformatf("p%0d_coll", p), 64'(co), 64'(exp_q[idx].coll));
      last_v[p] = exp_q[idx].data;
      exp_q.delete(idx);
    end else begin
      chk($sformatf("p%0d_valid", p), 64'(v), 64'd0);
      chk($sformatf("p%0d_hold", p), d, last_v[p]);
      if (p % 2 == 1) chk($sformatf("p%0d_coll", p), 64'(co), 64'd0);
    end
  endtask

  // One clock: model update at the posedge, DUT sampled at the following negedge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      for (int p = 0; p < 6; p++) last_v[p] = '0;
      for (int s = 0; s < 2; s++) for (int a = 0; a < DEPTH; a++) mdl[s][a] = '0;
      busy_rem = DEPTH;
    end else if (busy_rem > 0) begin
      busy_rem--;
    end else begin
      apply(0, csb0_a, web0_a, wmask0_a, addr0_a, 64'(din0_a), csb1_a, addr1_a);
      apply(1, csb0_c, web0_c, wmask0_c, addr0_c, din0_c, csb1_c, addr1_c);
    end
    @(negedge clk);
    chk("busy_a", 64'(busy_a), 64'(busy_rem > 0));
    chk("busy_b", 64'(busy_b), 64'(busy_rem > 0));
    chk("busy_c", 64'(busy_c), 64'(busy_rem > 0));
    check_port(0, v0_a, 64'(dout0_a), 1'b0);
    check_port(1, v1_a, 64'(dout1_a), coll_a);
    check_port(2, v0_b, 64'(dout0_b), 1'b0);
    check_port(3, v1_b, 64'(dout1_b), coll_b);
    check_port(4, v0_c, dout0_c, 1'b0);
    check_port(5, v1_c, dout1_c, coll_c);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_a(input logic c0, input logic w0, input logic [3:0] m, input logic [AW-1:0] a0,
                       input logic [31:0] d0, input logic c1, input logic [AW-1:0] a1);
    csb0_a = c0; web0_a = w0; wmask0_a = m; addr0_a = a0; din0_a = d0; csb1_a = c1; addr1_a = a1;
  endtask

  task automatic set_c(input logic c0, input logic w0, input logic [3:0] m, input logic [AW-1:0] a0,
                       input logic [63:0] d0, input logic c1, input logic [AW-1:0] a1);
    csb0_c = c0; web0_c = w0; wmask0_c = m; addr0_c = a0; din0_c = d0; csb1_c = c1; addr1_c = a1;
  endtask

  task automatic idle();
    set_a(1'b1, 1'b1, 4'd0, '0, '0, 1'b1, '0);
    set_c(1'b1, 1'b1, 4'd0, '0, '0, 1'b1, '0);
  endtask

  task automatic rand_inputs();
    logic [AW-1:0] a0a, a0c;
    a0a = AW'($urandom_range(0, DEPTH - 1));
    a0c = AW'($urandom_range(0, DEPTH - 1));
    set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a0a,
          $urandom, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0) ? a0a : AW'($urandom_range(0, DEPTH - 1)));
    set_c(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a0c,
          {$urandom, $urandom}, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0) ? a0c : AW'($urandom_range(0, DEPTH - 1)));
  endtask

  // Steps with random traffic until init_busy drops; traffic must be ignored meanwhile.
  task automatic busy_window(input string tag);
    int n, nv;
    n = 0; nv = 0;
    do begin
      rand_inputs();
      step();
      n++;
      nv += int'(v0_a) + int'(v1_a) + int'(v0_c) + int'(v1_c);
    end while (busy_a && n < 40);
    chk({tag, "_busy_len"}, 64'(n), 64'(DEPTH));
    chk({tag, "_busy_no_valid"}, 64'(nv), 64'd0);
    idle();
  endtask

  task automatic async_rst_check(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_dout0_a"}, 64'(dout0_a), 64'd0);
    chk({tag, "_dout1_a"}, 64'(dout1_a), 64'd0);
    chk({tag, "_dout1_b"}, 64'(dout1_b), 64'd0);
    chk({tag, "_dout1_c"}, dout1_c, 64'd0);
    chk({tag, "_valids"}, 64'({v0_a, v1_a, v0_b, v1_b, v0_c, v1_c}), 64'd0);
    chk({tag, "_coll"}, 64'({coll_a, coll_b, coll_c}), 64'd0);
    chk({tag, "_busy"}, 64'({busy_a, busy_b, busy_c}), 64'd7);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0; n_err = 0; cyc = 0; busy_rem = DEPTH;
    rst = 1'b1;
    idle();
    repeat (3) step();
    rst = 1'b0;
    busy_window("init");

    // every word reads back zero after the clear
    for (int a = 0; a < DEPTH; a++) begin
      set_a(1'b1, 1'b1, 4'd0, '0, '0, 1'b0, AW'(a));
      set_c(1'b0, 1'b1, 4'd0, AW'(a), '0, 1'b0, AW'(DEPTH - 1 - a));
      step();
    end
    idle();

    // lane-masked overwrite
    set_a(1'b0, 1'b0, 4'b1111, 4'h5, 32'hDEADBEEF, 1'b1, '0); step();
    set_a(1'b0, 1'b0, 4'b0101, 4'h5, 32'h11223344, 1'b1, '0); step();
    set_a(1'b0, 1'b1, 4'b0000, 4'h5, 32'h0, 1'b1, '0); step();
    chk("t2_rd_valid", 64'(v0_a), 64'd1);
    chk("t2_rd_data", 64'(dout0_a), 64'hDE22BE44);
    idle(); step();

    // write-first collision, then a non-colliding pair
    set_a(1'b0, 1'b0, 4'b1111, 4'h7, 32'h01020304, 1'b1, '0); step();
    set_a(1'b0, 1'b0, 4'b0011, 4'h7, 32'hAABBCCDD, 1'b0, 4'h7); step();
    chk("t3_coll_data", 64'(dout1_a), 64'h0102CCDD);
    chk("t3_coll_flag", 64'(coll_a), 64'd1);
    set_a(1'b0, 1'b0, 4'b1111, 4'h8, 32'h55555555, 1'b0, 4'h7); step();
    chk("t3_lat2_coll", 64'(coll_b), 64'd1);
    chk("t3_nocoll_flag", 64'(coll_a), 64'd0);
    chk("t3_nocoll_data", 64'(dout1_a), 64'h0102CCDD);
    idle(); step(); step();

    // latency-2 back-to-back reads
    for (int a = 1; a <= 3; a++) begin
      set_a(1'b0, 1'b0, 4'b1111, AW'(a), 32'h10101010 * a, 1'b1, '0); step();
    end
    for (int a = 1; a <= 5; a++) begin
      if (a <= 3) set_a(1'b1, 1'b1, 4'd0, '0, '0, 1'b0, AW'(a));
      else idle();
      step();
      if (a >= 2 && a <= 4) begin
        chk("t4_lat2_valid", 64'(v1_b), 64'd1);
        chk("t4_lat2_data", 64'(dout1_b), 64'h10101010 * (a - 1));
      end
    end
    chk("t4_lat2_done", 64'(v1_b), 64'd0);

    // wide lanes: only the top lane changes
    set_c(1'b0, 1'b0, 4'b1111, 4'h2, 64'h0123456789ABCDEF, 1'b1, '0); step();
    set_c(1'b0, 1'b0, 4'b1000, 4'h2, 64'hFFFFFFFFFFFFFFFF, 1'b1, '0); step();
    set_c(1'b0, 1'b1, 4'b0000, 4'h2, 64'h0, 1'b1, '0); step();
    chk("t6_wide_data", dout0_c, 64'hFFFF456789ABCDEF);
    idle(); step();

    for (int i = 0; i < 250; i++) begin
      rand_inputs();
      step();
    end
    idle();

    // asynchronous reset, then reset again part-way through the clear
    async_rst_check("rst_run");
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rand_inputs();
      step();
    end
    idle();
    async_rst_check("rst_mid");
    step();
    rst = 1'b0;
    busy_window("reclear");

    for (int i = 0; i < 120; i++) begin
      rand_inputs();
      step();
    end
    idle();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_param.md
Name: sram_1rw1r_param

Overview:
Parametrised, synthesisable 1RW+1R SRAM model. It is the next generation of the fixed 32x256 OpenRAM macro model and is generalised in width, depth, write-lane granularity and read latency. It adds a post-reset clear engine, read-valid strobes, and write-first collision bypass between ports. It sits in the RAM directory as a drop-in behavioural memory for simulation and FPGA builds.

Parameters:
DATA_WIDTH, 32, data word width in bits.
ADDR_WIDTH, 8, address width. DEPTH = 2**ADDR_WIDTH words.
LANE_WIDTH, 8, bits per write-mask lane. DATA_WIDTH must be a multiple of LANE_WIDTH. NUM_WMASKS = DATA_WIDTH/LANE_WIDTH.
READ_LATENCY, 1, cycles from accepted read to dout. Legal values are 1 and 2.
CLEAR_ON_RESET, 1, when 1, all words are zeroed after reset. When 0, there is no clear and contents are undefined.

Ports:
clk  in  1  single clock for both ports
rst  in  1  asynchronous, active-high reset
init_busy  out  1  high while the clear engine runs
csb0  in  1  port 0 chip select, active low
web0  in  1  port 0 write enable, active low
wmask0  in  NUM_WMASKS  per-lane write enable
addr0  in  ADDR_WIDTH  port 0 address
din0  in  DATA_WIDTH  port 0 write data
dout0  out  DATA_WIDTH  port 0 read data
dout0_valid  out  1  one-cycle strobe; dout0 is new
csb1  in  1  port 1 chip select, active low
addr1  in  ADDR_WIDTH  port 1 address
dout1  out  DATA_WIDTH  port 1 read data
dout1_valid  out  1  one-cycle strobe; dout1 is new
collision  out  1  one-cycle strobe aligned with dout1_valid; the read was bypassed from a same-cycle write

Behaviour:
- Reset (async assert) drives dout0, dout1, dout0_valid, dout1_valid and collision to 0, and clears all pipeline stages.
- init_busy goes to CLEAR_ON_RESET as soon as rst asserts.
- FSM states: CLEAR and RUN.
  - While rst is held, the state is CLEAR if CLEAR_ON_RESET is set, otherwise RUN.
  - In CLEAR, the clear pointer starts at 0 and writes all-zero to mem[ptr] each cycle, then increments.
  - After writing DEPTH-1, the FSM moves to RUN and init_busy falls. init_busy is high for exactly DEPTH cycles after rst deasserts.
  - If rst asserts mid-clear, the pointer restarts at 0.
- In CLEAR, both ports are ignored: no write, no valid strobe, dout holds.
- Port 0 write: in RUN with csb0=0 and web0=0, each lane i with wmask0[i]=1 is updated at the posedge. Other lanes are preserved. A write produces no dout0_valid and dout0 holds. wmask0=0 is a no-op.
- Port 0 read: in RUN with csb0=0 and web0=1, mem[addr0] is sampled at the posedge. It appears on dout0 READ_LATENCY cycles later with dout0_valid high for one cycle.
- Port 1 read: in RUN with csb1=0, behaviour is identical to a port 0 read, using addr1, dout1 and dout1_valid.
- Back-to-back reads are accepted every cycle, with full throughput.
- dout0 and dout1 hold their last value between strobes.
- Collision: a port 0 write with any wmask0 bit set, plus a port 1 read, at the same addr in the same cycle.
  - dout1 returns the merged word: din0 lanes where the mask is set, old contents elsewhere (write-first).
  - collision pulses with dout1_valid. No collision is flagged if wmask0=0 or the addresses differ.
- With READ_LATENCY=2, an extra register stage holds data, valid and collision. There are no bubbles.
- Addresses cover the full DEPTH, so there is no out-of-range case.
- Memory contents are not touched by rst except through the clear engine.

Decomposition:
- Package sram_pkg:
  - state enum {ST_CLEAR, ST_RUN}
  - function lane_merge(old, new, mask) parametrised by LANE_WIDTH
  - localparam LAT_MAX=2
- Sub-module sram_rd_pipe: carries data, valid and collision flag for READ_LATENCY stages, with async reset. It is instantiated once per read port; the collision input is tied 0 on port 0.

Test Plan:
1. CLEAR_ON_RESET=1, ADDR_WIDTH=4: release rst -> init_busy high exactly 16 cycles. Then a port 1 read of each address returns 0x00000000. A read issued during busy produces no dout1_valid.
2. Write addr0=0x05, din0=0xDEADBEEF, wmask0=4'b1111. Then write din0=0x11223344, wmask0=4'b0101 -> port 0 read of 0x05 returns 0xDE22BE44 one cycle later with dout0_valid=1.
3. Same cycle: port 0 writes 0xAABBCCDD with mask 4'b0011 to 0x07 (old 0x01020304), and port 1 reads 0x07 -> dout1=0x0102CCDD, collision=1. With different addresses -> collision=0.
4. READ_LATENCY=2: port 1 reads addresses 1, 2, 3 on consecutive cycles -> dout1_valid on cycles +2, +3, +4 with the correct data and no gaps.
5. Assert rst at clear pointer 9 -> all outputs go to 0 immediately. After release, init_busy lasts a full DEPTH cycles again.
6. DATA_WIDTH=64, LANE_WIDTH=16: a write with wmask0=4'b1000 changes only bits 63:48, checked by read-back.
